ps_pkt_scfifo: RTL and testbench

PS_PKT_SCFIFO -- requirements
Module: ps_pkt_scfifo

---
 rtl/ps_pkt_scfifo.sv | 137 +++++++++++++
 tb/tb_ps_pkt_scfifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_pkt_scfifo.sv
// Single-clock word FIFO with packet awareness: first-word-fall-through output,
// either cut-through (STREAM) or store-and-forward (PACKET) release of words.
module ps_pkt_scfifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    parameter     MODE   = "STREAM"
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DWIDTH-1:0]        i_dat,
    input  logic                     i_val,
    input  logic                     i_eop,
    output logic                     i_rdy,
    output logic [DWIDTH-1:0]        o_dat,
    output logic                     o_val,
    output logic                     o_eop,
    input  logic                     o_rdy,
    output logic [$clog2(DEPTH):0]   o_usedw,
    output logic [$clog2(DEPTH):0]   o_pkts
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam bit PKT_MODE = (MODE == "PACKET");
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE      = CW'(1);

    // Each entry holds {data, eop}.
    logic [DWIDTH:0]   mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     usedw_q, usedw_d;
    logic [CW-1:0]     pkts_q, pkts_d;
    logic              release_q, release_d;
    logic              i_rdy_q, i_rdy_d;

    logic              wr_en;
    logic              rd_en;
    logic              wr_eop;
    logic              rd_eop;
    logic              head_avail;

    assign wr_en  = i_val & i_rdy_q;
    assign rd_en  = o_val & o_rdy;
    assign wr_eop = wr_en & i_eop;
    assign rd_eop = rd_en & o_eop;

    assign head_avail = (usedw_q != '0);

    // The output side is driven only from registered state, so a word written
    // into an empty FIFO cannot reach o_val/o_dat until the following cycle.
    always_comb begin
        if (PKT_MODE) begin
            o_val = head_avail & ((pkts_q != '0) | release_q);
        end else begin
            o_val = head_avail;
        end
    end

    assign {o_dat, o_eop} = mem_q[rd_ptr_q];
    assign i_rdy          = i_rdy_q;
    assign o_usedw        = usedw_q;
    assign o_pkts         = pkts_q;

    // Next-state logic for pointers, counters and the PACKET release flag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        usedw_d   = usedw_q;
        pkts_d    = pkts_q;
        release_d = release_q;

        // DEPTH is a power of two, so the natural AW-bit rollover is the wrap.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   usedw_d = usedw_q + ONE;
            2'b01:   usedw_d = usedw_q - ONE;
            default: usedw_d = usedw_q;
        endcase

        case ({wr_eop, rd_eop})
            2'b10:   pkts_d = pkts_q + ONE;
            2'b01:   pkts_d = pkts_q - ONE;
            default: pkts_d = pkts_q;
        endcase

        // A full buffer with no complete packet would deadlock, so it is
        // released cut-through until the eop of that oversized packet leaves.
        if (PKT_MODE) begin
            if (rd_eop) begin
                release_d = 1'b0;
            end
            if ((usedw_d == FULL_CNT) && (pkts_d == '0)) begin
                release_d = 1'b1;
            end
        end else begin
            release_d = 1'b0;
        end

        i_rdy_d = (usedw_d < FULL_CNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usedw_q   <= '0;
            pkts_q    <= '0;
            release_q <= 1'b0;
            i_rdy_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            usedw_q   <= usedw_d;
            pkts_q    <= pkts_d;
            release_q <= release_d;
            i_rdy_q   <= i_rdy_d;
        end
    end

    // NOTE: the storage array is not reset; cleared pointers and counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {i_dat, i_eop};
        end
    end

endmodule

// File: tb/tb_ps_pkt_scfifo.sv
// Bench for ps_pkt_scfifo: a STREAM and a PACKET instance share stimulus and
// are compared every cycle against queue-based reference models.
module tb_ps_pkt_scfifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] i_dat;
    logic          i_val;
    logic          i_eop;
    logic          o_rdy;

    logic          s_i_rdy, s_o_val, s_o_eop;
    logic [DW-1:0] s_o_dat;
    logic [CW-1:0] s_o_usedw, s_o_pkts;
    logic          p_i_rdy, p_o_val, p_o_eop;
    logic [DW-1:0] p_o_dat;
    logic [CW-1:0] p_o_usedw, p_o_pkts;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference models: index 0 = STREAM, 1 = PACKET.
    logic [DW:0] q_s [$];
    logic [DW:0] q_p [$];
    int          m_pkts [2];
    bit          m_rel  [2];
    bit          m_rdy  [2];

    logic [DW-1:0] pkt_words [20];
    logic [DW-1:0] rx [$];

    always #5 clk = ~clk;

    ps_pkt_scfifo #(.DWIDTH(DW), .DEPTH(DEPTH), .MODE("STREAM")) u_stream (
        .clk(clk), .reset(reset),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(s_i_rdy),
        .o_dat(s_o_dat), .o_val(s_o_val), .o_eop(s_o_eop), .o_rdy(o_rdy),
        .o_usedw(s_o_usedw), .o_pkts(s_o_pkts)
    );

    ps_pkt_scfifo #(.DWIDTH(DW), .DEPTH(DEPTH), .MODE("PACKET")) u_packet (
        .clk(clk), .reset(reset),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(p_i_rdy),
        .o_dat(p_o_dat), .o_val(p_o_val), .o_eop(p_o_eop), .o_rdy(o_rdy),
        .o_usedw(p_o_usedw), .o_pkts(p_o_pkts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q_s.size() : q_p.size();
    endfunction

    function automatic logic [DW:0] qfront(input int m);
        return (m == 0) ? q_s[0] : q_p[0];
    endfunction

    function automatic logic [DW:0] qpop(input int m);
        return (m == 0) ? q_s.pop_front() : q_p.pop_front();
    endfunction

    function automatic void qpush(input int m, input logic [DW:0] v);
        if (m == 0) q_s.push_back(v);
        else        q_p.push_back(v);
    endfunction

    function automatic void model_reset(input int m);
        if (m == 0) q_s.delete();
        else        q_p.delete();
        m_pkts[m] = 0;
        m_rel[m]  = 1'b0;
        m_rdy[m]  = 1'b0;
    endfunction

    function automatic bit exp_oval(input int m);
        return (qsize(m) > 0) && ((m == 0) || (m_pkts[m] > 0) || m_rel[m]);
    endfunction

    function automatic void model_edge(input int m, input bit wr, input bit rd);
        logic [DW:0] h;
        bit rd_eop;
        rd_eop = 1'b0;
        if (!reset) begin
            model_reset(m);
            return;
        end
        if (rd) begin
            h = qpop(m);
            rd_eop = h[0];
        end
        if (wr) qpush(m, {i_dat, i_eop});
        if (wr && i_eop) m_pkts[m]++;
        if (rd_eop)      m_pkts[m]--;
        if (m == 1) begin
            if (rd_eop) m_rel[m] = 1'b0;
            if (qsize(m) == DEPTH && m_pkts[m] == 0) m_rel[m] = 1'b1;
        end
        m_rdy[m] = (qsize(m) < DEPTH);
    endfunction

    task automatic cmp_model(input int m, input string nm, input logic rdy, input logic val,
                             input logic [DW-1:0] dat, input logic eop,
                             input logic [CW-1:0] uw, input logic [CW-1:0] pk);
        logic [DW:0] h;
        check({nm, "_i_rdy"}, 32'(rdy), 32'(m_rdy[m]));
        check({nm, "_o_val"}, 32'(val), 32'(exp_oval(m)));
        check({nm, "_usedw"}, 32'(uw), 32'(qsize(m)));
        check({nm, "_pkts"},  32'(pk), 32'(m_pkts[m]));
        if (exp_oval(m)) begin
            h = qfront(m);
            check({nm, "_o_dat"}, 32'(dat), 32'(h[DW:1]));
            check({nm, "_o_eop"}, 32'(eop), 32'(h[0]));
        end
    endtask

    // Compare both DUTs with their models, then advance one clock edge.
    task automatic step();
        bit wr [2];
        bit rd [2];
        cmp_model(0, "S", s_i_rdy, s_o_val, s_o_dat, s_o_eop, s_o_usedw, s_o_pkts);
        cmp_model(1, "P", p_i_rdy, p_o_val, p_o_dat, p_o_eop, p_o_usedw, p_o_pkts);
        for (int m = 0; m < 2; m++) begin
            wr[m] = i_val && m_rdy[m];
            rd[m] = exp_oval(m) && o_rdy;
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_edge(m, wr[m], rd[m]);
        @(negedge clk);
    endtask

    task automatic drain(input int cycles);
        o_rdy = 1'b1;
        i_val = 1'b0;
        i_eop = 1'b0;
        for (int c = 0; c < cycles; c++) step();
    endtask

    initial begin
        int idx;
        int cyc;
        bit acc;

        reset = 1'b0;
        i_dat = '0;
        i_val = 1'b0;
        i_eop = 1'b0;
        o_rdy = 1'b0;
        model_reset(0);
        model_reset(1);

        // Reset state and i_rdy rising one edge after deassertion.
        @(negedge clk);
        check("rst_s_i_rdy", 32'(s_i_rdy), 32'd0);
        check("rst_p_o_val", 32'(p_o_val), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check("post_rst_s_i_rdy", 32'(s_i_rdy), 32'd1);
        check("post_rst_p_i_rdy", 32'(p_i_rdy), 32'd1);

        // Single word with eop, latency 1, then read.
        o_rdy = 1'b1;
        i_val = 1'b1;
        i_dat = 8'h5A;
        i_eop = 1'b1;
        step();
        i_val = 1'b0;
        i_eop = 1'b0;
        check("one_s_o_val", 32'(s_o_val), 32'd1);
        check("one_s_o_dat", 32'(s_o_dat), 32'h5A);
        check("one_s_usedw", 32'(s_o_usedw), 32'd1);
        step();
        check("one_s_usedw_after", 32'(s_o_usedw), 32'd0);

        // Fill to DEPTH with no eop; overflow attempt; one read frees space.
        o_rdy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            i_val = 1'b1;
            i_dat = 8'($urandom);
            step();
        end
        check("full_s_i_rdy", 32'(s_i_rdy), 32'd0);
        check("full_s_usedw", 32'(s_o_usedw), 32'd16);
        i_dat = 8'hEE;
        step();
        check("full_17th_usedw", 32'(s_o_usedw), 32'd16);
        check("full_p_release_val", 32'(p_o_val), 32'd1);
        i_val = 1'b0;
        o_rdy = 1'b1;
        step();
        check("full_read_i_rdy", 32'(s_i_rdy), 32'd1);
        i_val = 1'b1;
        i_eop = 1'b1;
        i_dat = 8'h77;
        step();
        drain(24);
        check("fill_drain_s_usedw", 32'(s_o_usedw), 32'd0);
        check("fill_drain_p_usedw", 32'(p_o_usedw), 32'd0);

        // Store-and-forward of a 5-word packet.
        o_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_val = 1'b1;
            i_dat = 8'(8'h10 + k);
            i_eop = (k == 4);
            step();
            if (k < 4) check("pkt5_p_o_val_low", 32'(p_o_val), 32'd0);
        end
        check("pkt5_p_o_val_high", 32'(p_o_val), 32'd1);
        check("pkt5_p_pkts", 32'(p_o_pkts), 32'd1);
        i_val = 1'b0;
        i_eop = 1'b0;
        o_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("pkt5_p_o_eop", 32'(p_o_eop), 32'(k == 4));
            step();
        end
        check("pkt5_p_pkts_end", 32'(p_o_pkts), 32'd0);
        drain(4);

        // Oversized 20-word packet drains through the release path.
        for (int k = 0; k < 20; k++) pkt_words[k] = 8'($urandom);
        rx.delete();
        o_rdy = 1'b1;
        idx = 0;
        cyc = 0;
        while ((idx < 20 || p_o_val) && cyc < 200) begin
            if (idx < 20) begin
                i_val = 1'b1;
                i_dat = pkt_words[idx];
                i_eop = (idx == 19);
            end else begin
                i_val = 1'b0;
                i_eop = 1'b0;
            end
            acc = i_val && p_i_rdy;
            if (p_o_val) rx.push_back(p_o_dat);
            step();
            if (acc) idx++;
            cyc++;
        end
        check("pkt20_budget", 32'(cyc < 200), 32'd1);
        check("pkt20_count", 32'(rx.size()), 32'd20);
        for (int k = 0; k < 20; k++) begin
            if (k < rx.size()) check("pkt20_order", 32'(rx[k]), 32'(pkt_words[k]));
        end
        i_val = 1'b1;
        i_eop = 1'b0;
        i_dat = 8'h33;
        step();
        i_val = 1'b0;
        step();
        check("pkt20_release_cleared", 32'(p_o_val), 32'd0);
        i_val = 1'b1;
        i_eop = 1'b1;
        i_dat = 8'h34;
        step();
        drain(8);

        // Hold occupancy at 8 under continuous write+read with random data.
        o_rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_val = 1'b1;
            i_eop = 1'b1;
            i_dat = 8'($urandom);
            step();
        end
        o_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            i_val = 1'b1;
            i_eop = 1'($urandom);
            i_dat = 8'($urandom);
            check("steady_s_usedw", 32'(s_o_usedw), 32'd8);
            step();
        end
        drain(40);
        check("steady_drain_s_usedw", 32'(s_o_usedw), 32'd0);

        // Asynchronous reset with a partial packet stored.
        o_rdy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            i_val = 1'b1;
            i_eop = 1'b0;
            i_dat = 8'($urandom);
            step();
        end
        i_val = 1'b0;
        check("pre_rst_s_usedw", 32'(s_o_usedw), 32'd7);
        reset = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check("arst_s_o_val", 32'(s_o_val), 32'd0);
        check("arst_s_usedw", 32'(s_o_usedw), 32'd0);
        check("arst_p_usedw", 32'(p_o_usedw), 32'd0);
        check("arst_p_pkts", 32'(p_o_pkts), 32'd0);
        check("arst_s_i_rdy", 32'(s_i_rdy), 32'd0);
        @(negedge clk);
        step();
        reset = 1'b1;
        step();
        check("rerst_s_i_rdy", 32'(s_i_rdy), 32'd1);
        check("rerst_p_i_rdy", 32'(p_i_rdy), 32'd1);
        i_val = 1'b1;
        i_eop = 1'b1;
        i_dat = 8'h3C;
        step();
        i_val = 1'b0;
        i_eop = 1'b0;
        check("no_residual_s_dat", 32'(s_o_dat), 32'h3C);
        check("no_residual_p_dat", 32'(p_o_dat), 32'h3C);
        check("no_residual_p_usedw", 32'(p_o_usedw), 32'd1);
        drain(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
